// File: rtl/frontend_pkg.sv
// Shared front-end types: PC select codes, redirect FSM states, pending-redirect entry.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package frontend_pkg;

    // PC width in bits. The fetch_redirect_ctrl WIDTH parameter must equal PC_W-1.
    localparam int PC_W  = 32;
    // Recovery counter width (covers RECOVER_CYCLES up to 15).
    localparam int CNT_W = 4;

    typedef enum logic [2:0] {
        SEL_SEQ   = 3'd0,
        SEL_BPU   = 3'd1,
        SEL_JAL   = 3'd2,
        SEL_EARLY = 3'd3,
        SEL_ROB   = 3'd4
    } pc_sel_t;

    typedef enum logic {
        RUN     = 1'b0,
        RECOVER = 1'b1
    } redir_state_t;

    // A held redirect. The src encoding doubles as priority: a larger code wins.
    typedef struct packed {
        logic            valid;
        pc_sel_t         src;
        logic [PC_W-1:0] target;
    } pend_entry_t;

    // 32-bit saturating increment.
    function automatic logic [31:0] sat_inc32(input logic [31:0] v, input logic en);
        return (en && (v != 32'hFFFF_FFFF)) ? (v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/redirect_pending_reg.sv
// Single-entry redirect hold buffer; a higher-priority write overwrites, equal/lower is dropped.
// Latency: write visible on pend the cycle after the edge; clear also takes effect at the edge.
// Backpressure: none; clr wins over a same-cycle write.
module redirect_pending_reg
    import frontend_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic            wr_vld,
    input  pc_sel_t         wr_src,
    input  logic [PC_W-1:0] wr_target,
    output pend_entry_t     pend
);

    pend_entry_t pend_q;
    pend_entry_t pend_d;

    // Next entry: clear, accept a strictly higher-priority request, or hold.
    always_comb begin
        pend_d = pend_q;
        if (clr) begin
            pend_d = '0;
        end else if (wr_vld && (!pend_q.valid || (wr_src > pend_q.src))) begin
            pend_d = '{valid: 1'b1, src: wr_src, target: wr_target};
        end
    end

    // Entry register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    assign pend = pend_q;

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// Fetch-PC redirect arbiter: ROB > pending > EARLY > JAL > BPU > SEQ, with post-mispredict freeze.
// Latency: combinational select/target/load for the current edge; held redirects release on first unstalled edge.
// Backpressure: backendStall blocks the PC load and parks EARLY/JAL in one pending entry; ROB ignores stall.
// Optional: define REDIRECT_PERF_EN to add saturating per-source redirect and recovery-cycle counters.
module fetch_redirect_ctrl
    import frontend_pkg::*;
#(
    parameter int WIDTH          = PC_W - 1,
    parameter int RECOVER_CYCLES = 3
)(
    input  logic             clk,
    input  logic             globalResetN,
    input  logic             robRedirect,
    input  logic [WIDTH:0]   robTarget,
    input  logic             earlyMisdirect,
    input  logic [WIDTH:0]   decodePC,
    input  logic             isJAL,
    input  logic [WIDTH:0]   jalTarget,
    input  logic             predictorHit,
    input  logic [WIDTH:0]   predictedPC,
    input  logic             backendStall,
    output logic             pcLoad,
    output pc_sel_t          pcSel,
    output logic [WIDTH:0]   redirectTarget,
    output logic             redirect,
    output logic             flushFetch,
    output logic             flushDecode,
    output logic             flushRename,
    output logic             recovering
`ifdef REDIRECT_PERF_EN
    ,
    output logic [31:0]      robRedirectCount,
    output logic [31:0]      earlyCount,
    output logic [31:0]      jalCount,
    output logic [31:0]      bpuCount,
    output logic [31:0]      recoverCycleCount
`endif
);

    localparam logic [CNT_W-1:0] RECOVER_LOAD = CNT_W'(RECOVER_CYCLES);

    redir_state_t     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    pend_entry_t      pend;
    logic             pend_clr;
    logic             pend_wr_vld;
    pc_sel_t          pend_wr_src;
    logic [WIDTH:0]   pend_wr_target;
    logic [WIDTH:0]   early_target;

    // Instruction after the misdirected one; wraps naturally at the PC width.
    assign early_target = decodePC + {{WIDTH{1'b0}}, 1'b1};

    redirect_pending_reg u_pending (
        .clk       (clk),
        .rst_n     (globalResetN),
        .clr       (pend_clr),
        .wr_vld    (pend_wr_vld),
        .wr_src    (pend_wr_src),
        .wr_target (pend_wr_target),
        .pend      (pend)
    );

    // State and recovery counter registers.
    always_ff @(posedge clk) begin
        if (!globalResetN) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: ROB always (re)starts recovery; RECOVER counts down and exits after the last frozen cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (robRedirect) begin
            state_d = RECOVER;
            cnt_d   = RECOVER_LOAD;
        end else if (state_q == RECOVER) begin
            cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
            if (cnt_q == {{(CNT_W-1){1'b0}}, 1'b1}) begin
                state_d = RUN;
            end
        end
    end

    // Outputs and pending-buffer control: arbitration, stall parking and release.
    always_comb begin
        pcLoad         = 1'b0;
        pcSel          = SEL_SEQ;
        redirectTarget = '0;
        flushFetch     = 1'b0;
        flushDecode    = 1'b0;
        flushRename    = 1'b0;
        recovering     = 1'b0;
        pend_clr       = 1'b0;
        pend_wr_vld    = 1'b0;
        pend_wr_src    = SEL_SEQ;
        pend_wr_target = '0;
        if (!globalResetN) begin
            // Everything quiet while reset is held.
        end else if (robRedirect) begin
            pcLoad         = 1'b1;
            pcSel          = SEL_ROB;
            redirectTarget = robTarget;
            flushFetch     = 1'b1;
            flushDecode    = 1'b1;
            flushRename    = 1'b1;
            pend_clr       = 1'b1;
        end else if (state_q == RECOVER) begin
            recovering = 1'b1;
        end else begin
            flushFetch = earlyMisdirect;
            if (backendStall) begin
                // Park the best of EARLY/JAL; the buffer decides whether it beats what is held.
                if (earlyMisdirect) begin
                    pend_wr_vld    = 1'b1;
                    pend_wr_src    = SEL_EARLY;
                    pend_wr_target = early_target;
                end else if (isJAL) begin
                    pend_wr_vld    = 1'b1;
                    pend_wr_src    = SEL_JAL;
                    pend_wr_target = jalTarget;
                end
            end else begin
                pcLoad = 1'b1;
                if (pend.valid) begin
                    pcSel          = pend.src;
                    redirectTarget = pend.target;
                    pend_clr       = 1'b1;
                end else if (earlyMisdirect) begin
                    pcSel          = SEL_EARLY;
                    redirectTarget = early_target;
                end else if (isJAL) begin
                    pcSel          = SEL_JAL;
                    redirectTarget = jalTarget;
                end else if (predictorHit) begin
                    pcSel          = SEL_BPU;
                    redirectTarget = predictedPC;
                end
            end
        end
        redirect = pcLoad && (pcSel == SEL_BPU);
    end

`ifdef REDIRECT_PERF_EN
    logic [31:0] rob_cnt_q, rob_cnt_d;
    logic [31:0] early_cnt_q, early_cnt_d;
    logic [31:0] jal_cnt_q, jal_cnt_d;
    logic [31:0] bpu_cnt_q, bpu_cnt_d;
    logic [31:0] rec_cnt_q, rec_cnt_d;

    // Count each applied redirect by source, plus every frozen cycle.
    always_comb begin
        rob_cnt_d   = sat_inc32(rob_cnt_q,   pcLoad && (pcSel == SEL_ROB));
        early_cnt_d = sat_inc32(early_cnt_q, pcLoad && (pcSel == SEL_EARLY));
        jal_cnt_d   = sat_inc32(jal_cnt_q,   pcLoad && (pcSel == SEL_JAL));
        bpu_cnt_d   = sat_inc32(bpu_cnt_q,   pcLoad && (pcSel == SEL_BPU));
        rec_cnt_d   = sat_inc32(rec_cnt_q,   recovering);
    end

    // Performance counter registers.
    always_ff @(posedge clk) begin
        if (!globalResetN) begin
            rob_cnt_q   <= '0;
            early_cnt_q <= '0;
            jal_cnt_q   <= '0;
            bpu_cnt_q   <= '0;
            rec_cnt_q   <= '0;
        end else begin
            rob_cnt_q   <= rob_cnt_d;
            early_cnt_q <= early_cnt_d;
            jal_cnt_q   <= jal_cnt_d;
            bpu_cnt_q   <= bpu_cnt_d;
            rec_cnt_q   <= rec_cnt_d;
        end
    end

    assign robRedirectCount  = rob_cnt_q;
    assign earlyCount        = early_cnt_q;
    assign jalCount          = jal_cnt_q;
    assign bpuCount          = bpu_cnt_q;
    assign recoverCycleCount = rec_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Bench for fetch_redirect_ctrl: directed scenarios then random traffic against a spec-level model.
// Latency: outputs sampled on the falling edge, model state advances with each rising edge.
// Backpressure: exercised through randomized and directed backendStall.
module tb_fetch_redirect_ctrl;

    localparam int RC = 3;

    logic        clk = 1'b0;
    logic        globalResetN;
    logic        robRedirect;
    logic [31:0] robTarget;
    logic        earlyMisdirect;
    logic [31:0] decodePC;
    logic        isJAL;
    logic [31:0] jalTarget;
    logic        predictorHit;
    logic [31:0] predictedPC;
    logic        backendStall;
    logic        pcLoad;
    logic [2:0]  pcSel;
    logic [31:0] redirectTarget;
    logic        redirect;
    logic        flushFetch;
    logic        flushDecode;
    logic        flushRename;
    logic        recovering;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model state: spec-level view (frozen cycles left, held request).
    bit          m_recover = 0;
    int          m_left = 0;
    bit          m_pv = 0;
    int          m_pk = 0;
    logic [31:0] m_pt = '0;

    fetch_redirect_ctrl #(.WIDTH(31), .RECOVER_CYCLES(RC)) dut (
        .clk            (clk),
        .globalResetN   (globalResetN),
        .robRedirect    (robRedirect),
        .robTarget      (robTarget),
        .earlyMisdirect (earlyMisdirect),
        .decodePC       (decodePC),
        .isJAL          (isJAL),
        .jalTarget      (jalTarget),
        .predictorHit   (predictorHit),
        .predictedPC    (predictedPC),
        .backendStall   (backendStall),
        .pcLoad         (pcLoad),
        .pcSel          (pcSel),
        .redirectTarget (redirectTarget),
        .redirect       (redirect),
        .flushFetch     (flushFetch),
        .flushDecode    (flushDecode),
        .flushRename    (flushRename),
        .recovering     (recovering)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        assert (got === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        globalResetN   = 1'b1;
        robRedirect    = 1'b0;
        robTarget      = '0;
        earlyMisdirect = 1'b0;
        decodePC       = '0;
        isJAL          = 1'b0;
        jalTarget      = '0;
        predictorHit   = 1'b0;
        predictedPC    = '0;
        backendStall   = 1'b0;
    endtask

    // Sample the DUT mid-cycle, compare against the model, then advance the model for the coming edge.
    task automatic sample(input string tag);
        logic        e_load;
        logic [2:0]  e_sel;
        logic [31:0] e_tgt;
        logic        e_ff, e_fd, e_fr, e_rec;
        int          kind;
        @(negedge clk);
        e_load = 0; e_sel = 0; e_tgt = 0; e_ff = 0; e_fd = 0; e_fr = 0; e_rec = 0;
        if (!globalResetN) begin
            // all quiet
        end else if (robRedirect) begin
            e_load = 1; e_sel = 4; e_tgt = robTarget; e_ff = 1; e_fd = 1; e_fr = 1;
        end else if (m_recover) begin
            e_rec = 1;
        end else begin
            e_ff = earlyMisdirect;
            if (!backendStall) begin
                e_load = 1;
                if (m_pv) begin
                    e_sel = 3'(m_pk); e_tgt = m_pt;
                end else if (earlyMisdirect) begin
                    e_sel = 3; e_tgt = decodePC + 32'd1;
                end else if (isJAL) begin
                    e_sel = 2; e_tgt = jalTarget;
                end else if (predictorHit) begin
                    e_sel = 1; e_tgt = predictedPC;
                end
            end
        end
        chk({tag, ".pcLoad"}, {31'd0, pcLoad}, {31'd0, e_load});
        chk({tag, ".pcSel"}, {29'd0, pcSel}, {29'd0, e_sel});
        chk({tag, ".target"}, redirectTarget, e_tgt);
        chk({tag, ".flags"}, {27'd0, redirect, flushFetch, flushDecode, flushRename, recovering},
            {27'd0, (e_load && e_sel == 3'd1), e_ff, e_fd, e_fr, e_rec});

        if (!globalResetN) begin
            m_recover = 0; m_left = 0; m_pv = 0;
        end else if (robRedirect) begin
            m_recover = 1; m_left = RC; m_pv = 0;
        end else if (m_recover) begin
            m_left--;
            if (m_left == 0) m_recover = 0;
        end else if (backendStall) begin
            kind = earlyMisdirect ? 3 : (isJAL ? 2 : 0);
            if (kind != 0 && (!m_pv || kind > m_pk)) begin
                m_pv = 1; m_pk = kind;
                m_pt = earlyMisdirect ? decodePC + 32'd1 : jalTarget;
            end
        end else begin
            m_pv = 0;
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input string tag);
        sample(tag);
        next_cycle();
    endtask

    initial begin
        idle();
        globalResetN = 1'b0;
        next_cycle();
        cyc("rst0");
        cyc("rst1");

        // Idle after reset: sequential fetch.
        idle();
        sample("idle");
        chk("idle_load", {31'd0, pcLoad}, 32'd1);
        chk("idle_sel", {29'd0, pcSel}, 32'd0);
        next_cycle();

        // ROB redirect beats a stalled JAL, then exactly RC frozen cycles.
        robRedirect = 1; robTarget = 32'h100; isJAL = 1; jalTarget = 32'h44; backendStall = 1;
        sample("rob");
        chk("rob_sel", {29'd0, pcSel}, 32'd4);
        chk("rob_tgt", redirectTarget, 32'h100);
        chk("rob_flush", {29'd0, flushFetch, flushDecode, flushRename}, 32'd7);
        next_cycle();
        idle();
        for (int i = 0; i < RC; i++) begin
            sample("frozen");
            chk("frozen_rec", {31'd0, recovering}, 32'd1);
            next_cycle();
        end
        sample("rob_exit");
        chk("rob_exit_load", {31'd0, pcLoad}, 32'd1);
        next_cycle();

        // Stall parks JAL, EARLY overwrites, later JAL dropped; EARLY released on unstall.
        backendStall = 1; isJAL = 1; jalTarget = 32'h40; cyc("st1");
        isJAL = 0; earlyMisdirect = 1; decodePC = 32'h20; cyc("st2");
        earlyMisdirect = 0; isJAL = 1; jalTarget = 32'h80; cyc("st3");
        isJAL = 0; cyc("st4");
        backendStall = 0; predictorHit = 1; predictedPC = 32'h999;
        sample("release");
        chk("release_sel", {29'd0, pcSel}, 32'd3);
        chk("release_tgt", redirectTarget, 32'h21);
        next_cycle();
        predictorHit = 0;
        sample("after_release");
        chk("after_release_sel", {29'd0, pcSel}, 32'd0);
        next_cycle();

        // EARLY target wraps at all-ones.
        earlyMisdirect = 1; decodePC = 32'hFFFF_FFFF;
        sample("wrap");
        chk("wrap_tgt", redirectTarget, 32'h0);
        chk("wrap_ff", {31'd0, flushFetch}, 32'd1);
        next_cycle();
        idle();

        // BPU hit followed.
        predictorHit = 1; predictedPC = 32'h1234; cyc("bpu");
        idle();

        // ROB redirect on the last frozen cycle restarts the full window.
        robRedirect = 1; robTarget = 32'h200; cyc("rob2");
        robRedirect = 0; cyc("r2a"); cyc("r2b");
        robRedirect = 1; robTarget = 32'h300;
        sample("rob3");
        chk("rob3_tgt", redirectTarget, 32'h300);
        next_cycle();
        robRedirect = 0;
        for (int i = 0; i < RC; i++) begin
            sample("refrozen");
            chk("refrozen_rec", {31'd0, recovering}, 32'd1);
            next_cycle();
        end
        cyc("r3_exit");

        // Reset mid-recovery, and reset with a parked request.
        robRedirect = 1; robTarget = 32'h500; cyc("rob4");
        robRedirect = 0; cyc("r4a");
        globalResetN = 0; isJAL = 1; jalTarget = 32'h66;
        sample("rst_mid");
        chk("rst_mid_out", {26'd0, pcLoad, pcSel, flushFetch, recovering}, 32'd0);
        next_cycle();
        idle();
        backendStall = 1; isJAL = 1; jalTarget = 32'h70; cyc("park");
        globalResetN = 0; isJAL = 0; cyc("rst_park");
        idle();
        sample("post_rst");
        chk("post_rst_sel", {29'd0, pcSel}, 32'd0);
        chk("post_rst_rec", {31'd0, recovering}, 32'd0);
        next_cycle();

        // Random traffic against the model.
        for (int n = 0; n < 800; n++) begin
            globalResetN   = ($urandom_range(0, 99) != 0);
            robRedirect    = ($urandom_range(0, 19) == 0);
            robTarget      = $urandom;
            earlyMisdirect = ($urandom_range(0, 3) == 0);
            decodePC       = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
            isJAL          = ($urandom_range(0, 3) == 0);
            jalTarget      = $urandom;
            predictorHit   = ($urandom_range(0, 2) == 0);
            predictedPC    = $urandom;
            backendStall   = ($urandom_range(0, 2) == 0);
            cyc("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/fetch_redirect_ctrl.md
Name: fetch_redirect_ctrl

Overview:
- Sequences the fetch-PC select datapath.
- Arbitrates redirect requests from four sources:
  - ROB branch/JALR mispredict
  - decode early-misdirect
  - rename JAL
  - branch-predictor hit
- Generates the PC load enable, select code and target, plus per-stage flushes.
- Holds lower-priority redirects that arrive during a backend stall, and runs a fixed-length recovery window after each ROB mispredict while the rename map is restored.

Parameters:
- WIDTH, 31, MSB index of PC (PC is WIDTH+1 bits, word-indexed).
- RECOVER_CYCLES, 3, cycles fetch stays frozen after a ROB redirect (range 1..15).

Ports:
- clk  in  1  clock.
- globalResetN  in  1  synchronous, active-low reset.
- robRedirect  in  1  ROB mispredict/JALR redirect valid.
- robTarget  in  WIDTH+1  ROB redirect address.
- earlyMisdirect  in  1  decode found a predicted non-branch.
- decodePC  in  WIDTH+1  PC of the misdirected instruction.
- isJAL  in  1  rename-stage JAL valid.
- jalTarget  in  WIDTH+1  JAL target.
- predictorHit  in  1  BPU hit this cycle.
- predictedPC  in  WIDTH+1  BPU target.
- backendStall  in  1  ROB full or no RS entry.
- pcLoad  out  1  PC register load enable.
- pcSel  out  3  0 SEQ, 1 BPU, 2 JAL, 3 EARLY, 4 ROB.
- redirectTarget  out  WIDTH+1  address to load when pcSel≠0.
- redirect  out  1  pcSel==BPU and pcLoad (prediction followed).
- flushFetch, flushDecode, flushRename  out  1 each  single-cycle stage flushes.
- recovering  out  1  high while in RECOVER.

Behaviour:
- FSM states: RUN, RECOVER. Reset (globalResetN=0 at a clk edge):
  - state=RUN, recovery counter=0, pending register invalid.
  - While reset is held: all outputs 0 except pcSel=0.
- ROB redirect, any state, any backendStall:
  - pcLoad=1, pcSel=4, redirectTarget=robTarget.
  - All three flushes=1 for that cycle only.
  - Clears the pending register.
  - Next cycle: RECOVER with counter=RECOVER_CYCLES.
  - A ROB redirect during RECOVER reloads the target and restarts the counter.
- RECOVER, no ROB redirect:
  - pcLoad=0, recovering=1, all other redirect inputs ignored.
  - Counter decrements each cycle; on counter==1 the next state is RUN.
  - Frozen length is exactly RECOVER_CYCLES cycles.
- RUN, combinational priority (same cycle): valid pending > earlyMisdirect > isJAL > predictorHit > sequential.
  - EARLY target = decodePC+1, modulo 2^(WIDTH+1), so all-ones wraps to 0.
  - JAL target = jalTarget; BPU target = predictedPC.
  - SEQ: pcSel=0, redirectTarget=0 (datapath increments).
- earlyMisdirect in RUN, no ROB redirect: flushFetch=1 that cycle.
- RUN with backendStall=1:
  - pcLoad=0.
  - Any EARLY or JAL request is written to the single pending entry (source code + target).
  - A higher-priority request overwrites a lower one; an equal or lower one is dropped.
  - BPU hits during a stall are not held.
- First RUN cycle with backendStall=0 and pending valid:
  - pcLoad=1, pending source/target drive pcSel/redirectTarget.
  - Pending is cleared at the edge.
  - A simultaneous new EARLY or JAL is replaced by the pending entry and not stored.
- Latency: ROB redirect takes effect at the same edge (combinational to PC register). Pending release happens at the first unstalled edge.

Optional Feature:
- REDIRECT_PERF_EN defined:
  - Adds 32-bit saturating counters, each incremented once per applied redirect: robRedirectCount, earlyCount, jalCount, bpuCount.
  - Adds recoverCycleCount (cycles in RECOVER).
  - All exposed as outputs and zeroed on reset.
- Undefined: these ports and registers do not exist.

Decomposition:
- Shared package frontend_pkg holds:
  - typedef enum logic[2:0] pc_sel_t {SEL_SEQ, SEL_BPU, SEL_JAL, SEL_EARLY, SEL_ROB}
  - typedef enum logic redir_state_t {RUN, RECOVER}
  - pending-entry struct {valid, pc_sel_t src, target}
- One sub-module: redirect_pending_reg, holding the single-entry priority-overwrite buffer.

Test Plan:
- Reset then idle, no requests → pcLoad=1, pcSel=0, all flushes 0, recovering=0.
- robRedirect=1 with robTarget=0x100 while isJAL=1 and backendStall=1:
  - Same cycle: pcSel=4, target 0x100, pcLoad=1, three flushes=1.
  - Next 3 cycles: pcLoad=0, recovering=1. Cycle 4: RUN.
- backendStall=1 for 4 cycles:
  - JAL (0x40) in cycle 1, earlyMisdirect with decodePC=0x20 in cycle 2, JAL (0x80) in cycle 3.
  - On stall release: pcSel=3, target 0x21, pcLoad=1. Next cycle: SEQ.
- earlyMisdirect with decodePC=0xFFFFFFFF → target 0x00000000, flushFetch=1.
- ROB redirect at recovery counter=1 → counter restarts at 3, new target loaded.
- globalResetN=0 mid-RECOVER with pending valid → next cycle RUN, pending invalid, outputs 0.
